// File: rtl/count_cmd_sequencer.sv
// Command sequencer driving a WIDTH-bit up-counter: LOAD/RUN/CLR over valid/ready,
// with load-verify, stall and wrap monitoring. Define CNT_SEQ_ASSERT_EN for embedded assertions.
module count_cmd_sequencer #(
  parameter int WIDTH       = 4,
  parameter int STEP_W      = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_data,
  input  logic              abort,
  input  logic [WIDTH-1:0]  count_val,
  output logic              enable,
  output logic              load,
  output logic [WIDTH-1:0]  load_val,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              load_err,
  output logic              stall_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_RUN} state_e;
  typedef enum logic [1:0] {OP_CLR = 2'b00, OP_LOAD = 2'b01, OP_RUN = 2'b10, OP_RSVD = 2'b11} op_e;

  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0]   STALL_LAST = SC_W'(STALL_LIMIT - 1);
  localparam logic [WIDTH-1:0]  CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              enable_q, enable_d;
  logic              load_q, load_d;
  logic [WIDTH-1:0]  load_val_q, load_val_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              load_err_q, load_err_d;
  logic              stall_err_q, stall_err_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic              same_sample;

  assign same_sample = have_prev_q && (count_val == prev_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    enable_d    = enable_q;
    load_d      = 1'b0;
    load_val_d  = load_val_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    load_err_d  = load_err_q;
    stall_err_d = stall_err_q;
    steps_d     = steps_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      S_IDLE: begin
        enable_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          case (cmd_op)
            OP_CLR: begin
              load_err_d  = 1'b0;
              stall_err_d = 1'b0;
              done_d      = 1'b1;
            end
            OP_LOAD: begin
              state_d    = S_LOAD;
              load_d     = 1'b1;
              load_val_d = cmd_data[WIDTH-1:0];
            end
            OP_RUN: begin
              if (cmd_data == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = S_RUN;
                enable_d    = 1'b1;
                steps_d     = cmd_data;
                have_prev_d = 1'b0;
                stall_cnt_d = '0;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_LOAD: state_d = S_VERIFY;
      S_VERIFY: begin
        if (count_val != load_val_q) load_err_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (abort) begin
          enable_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          prev_d      = count_val;
          have_prev_d = 1'b1;
          if (steps_q != '0) steps_d = steps_q - STEP_ONE;
          if (have_prev_q && prev_q == CNT_MAX && count_val == '0) wrap_d = 1'b1;
          stall_cnt_d = same_sample ? stall_cnt_q + 1'b1 : '0;
          // A stall is an error and wins over a coincident final step.
          if (same_sample && stall_cnt_q == STALL_LAST) begin
            stall_err_d = 1'b1;
            enable_d    = 1'b0;
            state_d     = S_IDLE;
          end else if (steps_q == STEP_ONE) begin
            enable_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      enable_q    <= 1'b0;
      load_q      <= 1'b0;
      load_val_q  <= '0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      load_err_q  <= 1'b0;
      stall_err_q <= 1'b0;
      steps_q     <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      enable_q    <= enable_d;
      load_q      <= load_d;
      load_val_q  <= load_val_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      load_err_q  <= load_err_d;
      stall_err_q <= stall_err_d;
      steps_q     <= steps_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign enable    = enable_q;
  assign load      = load_q;
  assign load_val  = load_val_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;
  assign stall_err = stall_err_q;

`ifdef CNT_SEQ_ASSERT_EN
  a_load_enable_excl: assert property (@(posedge clk) disable iff (!rst) !(load && enable));
  a_load_one_cycle:   assert property (@(posedge clk) disable iff (!rst) load |=> !load);
  a_enable_in_run:    assert property (@(posedge clk) disable iff (!rst) enable |-> state_q == S_RUN);
  a_ready_not_busy:   assert property (@(posedge clk) disable iff (!rst) cmd_ready |-> !busy);
  a_done_pulse:       assert property (@(posedge clk) disable iff (!rst) $rose(done) |=> !done);
`else
  // Assertions compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_count_cmd_sequencer.sv
// Directed bench for count_cmd_sequencer with a behavioural 4-bit counter in the feedback loop.
module tb_count_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       abort = 1'b0;
  logic [3:0] count_val = 4'h0;
  logic       cmd_ready, enable, load, busy, done, wrap, load_err, stall_err;
  logic [3:0] load_val;

  logic ignore_load = 1'b0;
  logic frozen = 1'b0;
  int   tests = 0;
  int   fails = 0;

  count_cmd_sequencer #(.WIDTH(4), .STEP_W(8), .STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .count_val(count_val),
    .enable(enable), .load(load), .load_val(load_val), .busy(busy), .done(done),
    .wrap(wrap), .load_err(load_err), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  // Counter model: can be told to ignore loads or to stop counting.
  always @(posedge clk) begin
    if (load && !ignore_load) count_val <= load_val;
    else if (enable && !frozen) count_val <= count_val + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) tick();
    tests++; if ({enable, load, load_val, cmd_ready, busy, done, wrap, load_err, stall_err} !== 12'h000) begin
      fails++; $display("FAIL reset_outputs: got %b want all 0", {enable, load, load_val, cmd_ready, busy, done, wrap, load_err, stall_err}); end
    rst = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready); end
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b want 1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_reset: got %b want 0", busy); end
  endtask

  task automatic test_load_ok();
    send(2'b01, 8'h09);
    tests++; if ({load, enable, busy, cmd_ready} !== 4'b1010) begin fails++; $display("FAIL load_t0 {load,en,busy,rdy}: got %b want 1010", {load, enable, busy, cmd_ready}); end
    tests++; if (load_val !== 4'h9) begin fails++; $display("FAIL load_val: got %h want 9", load_val); end
    tick();
    tests++; if ({load, busy, done} !== 3'b010) begin fails++; $display("FAIL load_t1 {load,busy,done}: got %b want 010", {load, busy, done}); end
    tests++; if (count_val !== 4'h9) begin fails++; $display("FAIL counter_captured: got %h want 9", count_val); end
    tick();
    tests++; if ({done, load_err, cmd_ready, busy} !== 4'b1010) begin fails++; $display("FAIL load_t2 {done,lerr,rdy,busy}: got %b want 1010", {done, load_err, cmd_ready, busy}); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL load_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_load_err();
    ignore_load = 1'b1;
    send(2'b01, 8'h03);
    tick();
    tick();
    tests++; if ({done, load_err} !== 2'b11) begin fails++; $display("FAIL load_err_set {done,lerr}: got %b want 11", {done, load_err}); end
    ignore_load = 1'b0;
    tick();
    tick();
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL load_err_sticky: got %b want 1", load_err); end
    send(2'b00, 8'h00);
    tests++; if ({done, load_err, busy} !== 3'b100) begin fails++; $display("FAIL clr_load_err {done,lerr,busy}: got %b want 100", {done, load_err, busy}); end
    tick();
  endtask

  task automatic test_wrap_run();
    logic [3:0] exp_cnt;
    send(2'b01, 8'h0D);
    repeat (3) tick();
    send(2'b10, 8'd5);
    for (int j = 0; j < 5; j++) begin
      exp_cnt = 4'(13 + j);
      tests++; if ({enable, load, done} !== 3'b100) begin fails++; $display("FAIL run_step%0d {en,load,done}: got %b want 100", j, {enable, load, done}); end
      tests++; if (count_val !== exp_cnt) begin fails++; $display("FAIL run_count%0d: got %h want %h", j, count_val, exp_cnt); end
      tests++; if (wrap !== (j == 4)) begin fails++; $display("FAIL run_wrap%0d: got %b want %b", j, wrap, (j == 4)); end
      tick();
    end
    tests++; if ({enable, done, wrap, cmd_ready} !== 4'b0101) begin fails++; $display("FAIL run_end {en,done,wrap,rdy}: got %b want 0101", {enable, done, wrap, cmd_ready}); end
    tests++; if (count_val !== 4'h2) begin fails++; $display("FAIL run_final_count: got %h want 2", count_val); end
    tick();
  endtask

  task automatic test_back_to_back();
    send(2'b10, 8'd1);
    tests++; if (enable !== 1'b1) begin fails++; $display("FAIL b2b_enable: got %b want 1", enable); end
    tick();
    tests++; if ({done, enable, cmd_ready} !== 3'b101) begin fails++; $display("FAIL b2b_done {done,en,rdy}: got %b want 101", {done, enable, cmd_ready}); end
    send(2'b01, 8'h04);
    tests++; if ({load, load_val, done} !== 6'b1_0100_0) begin fails++; $display("FAIL b2b_load {load,val,done}: got %b want 101000", {load, load_val, done}); end
    tick();
    tick();
    tests++; if ({done, load_err} !== 2'b10) begin fails++; $display("FAIL b2b_load_done {done,lerr}: got %b want 10", {done, load_err}); end
    tick();
  endtask

  task automatic test_stall();
    send(2'b01, 8'h07);
    repeat (3) tick();
    frozen = 1'b1;
    send(2'b10, 8'd10);
    for (int j = 0; j < 5; j++) begin
      tests++; if ({enable, stall_err} !== 2'b10) begin fails++; $display("FAIL stall_step%0d {en,serr}: got %b want 10", j, {enable, stall_err}); end
      tick();
    end
    tests++; if ({enable, stall_err, busy, done, cmd_ready} !== 5'b01001) begin fails++; $display("FAIL stall_hit {en,serr,busy,done,rdy}: got %b want 01001", {enable, stall_err, busy, done, cmd_ready}); end
    tick();
    tests++; if ({done, stall_err} !== 2'b01) begin fails++; $display("FAIL stall_no_done {done,serr}: got %b want 01", {done, stall_err}); end
    frozen = 1'b0;
    send(2'b00, 8'h00);
    tests++; if ({done, stall_err} !== 2'b10) begin fails++; $display("FAIL clr_stall {done,serr}: got %b want 10", {done, stall_err}); end
    tick();
  endtask

  task automatic test_abort_run0();
    send(2'b10, 8'd8);
    tick();
    tick();
    tests++; if (enable !== 1'b1) begin fails++; $display("FAIL abort_pre_enable: got %b want 1", enable); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({enable, busy, done, cmd_ready} !== 4'b0001) begin fails++; $display("FAIL abort {en,busy,done,rdy}: got %b want 0001", {enable, busy, done, cmd_ready}); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b want 0", done); end
    send(2'b10, 8'd0);
    tests++; if ({done, enable, busy} !== 3'b100) begin fails++; $display("FAIL run0 {done,en,busy}: got %b want 100", {done, enable, busy}); end
    tick();
    send(2'b11, 8'hFF);
    tests++; if ({done, busy, load, enable} !== 4'b1000) begin fails++; $display("FAIL reserved {done,busy,load,en}: got %b want 1000", {done, busy, load, enable}); end
    tick();
  endtask

  task automatic test_reset_mid();
    send(2'b10, 8'd8);
    tick();
    tests++; if ({enable, busy} !== 2'b11) begin fails++; $display("FAIL mid_pre {en,busy}: got %b want 11", {enable, busy}); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({enable, busy, cmd_ready, done} !== 4'b0000) begin fails++; $display("FAIL mid_reset {en,busy,rdy,done}: got %b want 0000", {enable, busy, cmd_ready, done}); end
    tick();
    rst = 1'b1;
    #1;
    tests++; if ({cmd_ready, enable} !== 2'b00) begin fails++; $display("FAIL mid_release {rdy,en}: got %b want 00", {cmd_ready, enable}); end
    tick();
    tests++; if ({cmd_ready, enable, busy} !== 3'b100) begin fails++; $display("FAIL mid_ready {rdy,en,busy}: got %b want 100", {cmd_ready, enable, busy}); end
  endtask

  initial begin
    test_reset();
    test_load_ok();
    test_load_err();
    test_wrap_run();
    test_back_to_back();
    test_stall();
    test_abort_run0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
